mips_cpu_regfile_write_ctrl: RTL

Owns the single write port of the 32x32 register file. Arbitrates between two writeback requesters: src0 (ALU/execute result) and src1 (load / multiply-divide result). Keeps a pending-destination scoreboard so the decode stage can stall on read-after-write hazards. Sits between the writeback sources and the register file; drives the register file's writeEnable, writeAddress and dataIn.

---
 rtl/mips_cpu_pkg.sv | 15 +
 rtl/mips_cpu_rr_arbiter2.sv | 53 +++++
 rtl/mips_cpu_regfile_write_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU register-file writeback path.
package mips_cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [4:0] reg_addr_t;

    // Identifies a writeback source, used both for the arbiter's priority pointer and its grant.
    typedef enum logic {
        WB_SRC0 = 1'b0,
        WB_SRC1 = 1'b1
    } wb_src_t;

endpackage

// File: rtl/mips_cpu_rr_arbiter2.sv
// Two-requester arbiter for the register-file write port, with an optional
// round-robin priority pointer. Grants are suppressed while reset is high.
module mips_cpu_rr_arbiter2
    import mips_cpu_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    req0,
    input  logic    req1,
    output logic    gnt0,
    output logic    gnt1,
    output logic    gnt_any,
    output wb_src_t gnt_src
);

    wb_src_t ptr;
    logic    contended;

    assign contended = req0 && req1;

    // Pick at most one winner; under contention the pointer decides unless round-robin is disabled.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (contended) begin
                if ((ROUND_ROBIN != 0) && (ptr == WB_SRC1)) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        gnt_any = gnt0 || gnt1;
        gnt_src = gnt1 ? WB_SRC1 : WB_SRC0;
    end

    // Hand priority to the loser after a contended grant; uncontended grants leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= WB_SRC0;
        end else if (contended && gnt_any) begin
            ptr <= (gnt_src == WB_SRC0) ? WB_SRC1 : WB_SRC0;
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_write_ctrl.sv
// Register-file write-port controller: arbitrates two writeback sources,
// registers the winning write, and keeps a pending-destination scoreboard
// that decode uses to detect read-after-write hazards.
module mips_cpu_regfile_write_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int DATA_W      = mips_cpu_pkg::DATA_W,
    parameter int ADDR_W      = mips_cpu_pkg::ADDR_W,
    parameter int NUM_REGS    = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                issue_ready,

    input  logic                src0_valid,
    input  logic [ADDR_W-1:0]   src0_addr,
    input  logic [DATA_W-1:0]   src0_data,
    output logic                src0_ready,

    input  logic                src1_valid,
    input  logic [ADDR_W-1:0]   src1_addr,
    input  logic [DATA_W-1:0]   src1_data,
    output logic                src1_ready,

    output logic                writeEnable,
    output logic [ADDR_W-1:0]   writeAddress,
    output logic [DATA_W-1:0]   dataIn,

    input  logic [ADDR_W-1:0]   readAddressA,
    input  logic [ADDR_W-1:0]   readAddressB,
    output logic                hazardA,
    output logic                hazardB,
    output logic [NUM_REGS-1:0] pending
);

    logic                gnt0;
    logic                gnt1;
    logic                gnt_any;
    wb_src_t             gnt_src;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;
    logic                gnt_writes;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pending_next;

    mips_cpu_rr_arbiter2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0    (src0_valid),
        .req1    (src1_valid),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_any (gnt_any),
        .gnt_src (gnt_src)
    );

    assign src0_ready = gnt0;
    assign src1_ready = gnt1;

    // Route the winner's address and data; r0 grants are accepted but never reach the register file.
    always_comb begin
        gnt_addr   = (gnt_src == WB_SRC1) ? src1_addr : src0_addr;
        gnt_data   = (gnt_src == WB_SRC1) ? src1_data : src0_data;
        gnt_writes = gnt_any && (gnt_addr != '0);
    end

    // A destination may be reserved if it is r0, free, or being retired by this cycle's grant.
    always_comb begin
        issue_ready = 1'b0;
        if (!reset) begin
            issue_ready = (issue_dest == '0) || !pending[issue_dest] ||
                          (gnt_any && (gnt_addr == issue_dest));
        end
    end

    // Next scoreboard: clear the retiring destination, then apply the new reservation so set wins.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_ready && (issue_dest != '0)) begin
            set_vec[issue_dest] = 1'b1;
        end
        if (gnt_any) begin
            clr_vec[gnt_addr] = 1'b1;
        end
        pending_next    = (pending & ~clr_vec) | set_vec;
        pending_next[0] = 1'b0;
    end

    // Scoreboard register; clears land on the same edge that raises writeEnable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Register the granted write one cycle after the grant; address and data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            dataIn       <= '0;
        end else begin
            writeEnable <= gnt_writes;
            if (gnt_writes) begin
                writeAddress <= gnt_addr;
                dataIn       <= gnt_data;
            end
        end
    end

    // Decode stalls on any source register whose write is still outstanding.
    always_comb begin
        hazardA = pending[readAddressA];
        hazardB = pending[readAddressB];
    end

endmodule
